riscv_mem_arbiter: RTL

Two-port arbiter that shares the single data-memory port (req/we/be/addr/wd/rd/ready handshake) between the instruction-fetch requester (port 0) and the load/store unit (port 1). It sits between those two masters and the memory, selects one request at a time with round-robin fairness, and holds the grant until the memory signals ready. A watchdog terminates stuck transactions with an error response so the core never stalls forever.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/riscv_mem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the core's memory-side blocks.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction fetch (port 0)
// and the load/store unit (port 1), with a watchdog that force-completes stuck transfers.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wd_i,
    output logic [31:0] m0_rd_o,
    output logic        m0_ready_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wd_i,
    output logic [31:0] m1_rd_o,
    output logic        m1_ready_o,
    output logic        m1_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam bit          WDOG_EN = (TIMEOUT_CYC != 0);
    localparam int unsigned CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Counter holds cycles waited beyond the issue cycle; it reads LIMIT in cycle TIMEOUT_CYC.
    localparam int unsigned LIMIT   = WDOG_EN ? TIMEOUT_CYC - 1 : 0;

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic sel;
    logic active;
    logic done;
    logic tmo;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant selection, lock tracking and watchdog.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel     = 1'b0;
        active  = 1'b0;
        done    = 1'b0;
        tmo     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rst_i && (m0_req_i || m1_req_i)) begin
                    sel    = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
                    active = 1'b1;
                    last_d = sel;
                    cnt_d  = '0;
                    if (mem_ready_i) begin
                        done = 1'b1;
                    end else begin
                        state_d = sel ? BUSY1 : BUSY0;
                    end
                end
            end
            BUSY0, BUSY1: begin
                sel    = (state_q == BUSY1);
                active = !rst_i;
                if (mem_ready_i) begin
                    done    = !rst_i;
                    state_d = IDLE;
                end else if (WDOG_EN && (cnt_q == CNT_W'(LIMIT))) begin
                    tmo     = !rst_i;
                    state_d = IDLE;
                end else if (WDOG_EN && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side mux follows the granted or locked port; zero when nothing is active.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        if (active) begin
            mem_req_o  = sel ? m1_req_i  : m0_req_i;
            mem_we_o   = sel ? m1_we_i   : m0_we_i;
            mem_be_o   = sel ? m1_be_i   : m0_be_i;
            mem_addr_o = sel ? m1_addr_i : m0_addr_i;
            mem_wd_o   = sel ? m1_wd_i   : m0_wd_i;
        end
    end

    always_comb begin
        m0_ready_o = (done || tmo) && !sel;
        m1_ready_o = (done || tmo) && sel;
        m0_err_o   = tmo && !sel;
        m1_err_o   = tmo && sel;
        m0_rd_o    = (done && !sel) ? mem_rd_i : '0;
        m1_rd_o    = (done && sel)  ? mem_rd_i : '0;
    end

endmodule
